// File: rtl/conf_int_mac_pipe_if.sv
// Operand/result handshake bundle for conf_int_mac_pipe.
// master drives operations and out_ready; slave is the MAC.
interface conf_int_mac_pipe_if #(
    parameter int unsigned OP_BITWIDTH  = 16,
    parameter int unsigned ACC_BITWIDTH = 40
);
    logic                    in_valid;
    logic                    in_ready;
    logic [OP_BITWIDTH-1:0]  a;
    logic [OP_BITWIDTH-1:0]  b;
    logic [OP_BITWIDTH-1:0]  c;
    logic                    apx__p;
    logic                    acc_mode;
    logic                    acc_clr;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_BITWIDTH-1:0] d;
    logic                    ovf;

    modport master (
        output in_valid, a, b, c, apx__p, acc_mode, acc_clr, out_ready,
        input  in_ready, out_valid, d, ovf
    );

    modport slave (
        input  in_valid, a, b, c, apx__p, acc_mode, acc_clr, out_ready,
        output in_ready, out_valid, d, ovf
    );
endinterface

// File: rtl/conf_int_mac_pipe.sv
// Three-stage configurable-precision integer MAC with running accumulator.
// Define CONF_MAC_OVF_EN to build the sticky accumulator-overflow flag.
module conf_int_mac_pipe #(
    parameter int unsigned OP_BITWIDTH  = 16,
    parameter int unsigned Pn           = 8,
    parameter int unsigned ACC_BITWIDTH = 40
) (
    input logic                clk,
    input logic                rst,
    conf_int_mac_pipe_if.slave bus
);
    localparam int unsigned HW = OP_BITWIDTH - Pn;
    localparam int unsigned PW = 2 * OP_BITWIDTH;
    localparam int unsigned RW = ACC_BITWIDTH + 1;

    logic en;

    logic [2*Pn-1:0]        ll_d, ll_q;
    logic [OP_BITWIDTH-1:0] hl_d, hl_q;
    logic [OP_BITWIDTH-1:0] lh_d, lh_q;
    logic [2*HW-1:0]        hh_d, hh_q;
    logic [OP_BITWIDTH-1:0] c1_q;
    logic                   apx1_q, accm1_q, clr1_q, v1_q;

    logic [PW-1:0]          p_d, p_q;
    logic [OP_BITWIDTH-1:0] cp_d, cp_q;
    logic                   accm2_q, clr2_q, v2_q;

    logic [ACC_BITWIDTH-1:0] base;
    logic [ACC_BITWIDTH-1:0] acc_q;
    logic [ACC_BITWIDTH-1:0] d_q;
    logic [RW-1:0]           r;
    logic                    out_valid_q;

    // Whole pipe moves as one; only a held result blocks it.
    assign en            = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;

    always_comb begin
        ll_d = {{Pn{1'b0}}, bus.a[Pn-1:0]} * {{Pn{1'b0}}, bus.b[Pn-1:0]};
        hl_d = {{Pn{1'b0}}, bus.a[OP_BITWIDTH-1:Pn]} * {{HW{1'b0}}, bus.b[Pn-1:0]};
        lh_d = {{HW{1'b0}}, bus.a[Pn-1:0]} * {{Pn{1'b0}}, bus.b[OP_BITWIDTH-1:Pn]};
        hh_d = {{HW{1'b0}}, bus.a[OP_BITWIDTH-1:Pn]} * {{HW{1'b0}}, bus.b[OP_BITWIDTH-1:Pn]};
    end

    always_comb begin
        p_d = PW'(hh_q) << (2 * Pn);
        if (!apx1_q) begin
            p_d = p_d + (PW'(lh_q) << Pn) + (PW'(hl_q) << Pn) + PW'(ll_q);
        end
        cp_d = c1_q;
        if (apx1_q) begin
            cp_d = (c1_q >> (2 * Pn)) << (2 * Pn);
        end
    end

    // acc_q already holds the previous commit, so back-to-back accumulation needs no forwarding.
    always_comb begin
        base = (accm2_q && !clr2_q) ? acc_q : '0;
        r    = RW'(base) + RW'(p_q) + RW'(cp_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ll_q        <= '0;
            hl_q        <= '0;
            lh_q        <= '0;
            hh_q        <= '0;
            c1_q        <= '0;
            apx1_q      <= 1'b0;
            accm1_q     <= 1'b0;
            clr1_q      <= 1'b0;
            v1_q        <= 1'b0;
            p_q         <= '0;
            cp_q        <= '0;
            accm2_q     <= 1'b0;
            clr2_q      <= 1'b0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            ll_q        <= ll_d;
            hl_q        <= hl_d;
            lh_q        <= lh_d;
            hh_q        <= hh_d;
            c1_q        <= bus.c;
            apx1_q      <= bus.apx__p;
            accm1_q     <= bus.acc_mode;
            clr1_q      <= bus.acc_clr;
            v1_q        <= bus.in_valid;
            p_q         <= p_d;
            cp_q        <= cp_d;
            accm2_q     <= accm1_q;
            clr2_q      <= clr1_q;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v2_q) begin
                d_q <= r[ACC_BITWIDTH-1:0];
                if (accm2_q) begin
                    acc_q <= r[ACC_BITWIDTH-1:0];
                end
            end
        end
    end

`ifdef CONF_MAC_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (en && v2_q) begin
            if (accm2_q && r[ACC_BITWIDTH]) begin
                ovf_q <= 1'b1;
            end else if (clr2_q) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_carry;
    assign unused_carry = r[ACC_BITWIDTH];
    assign bus.ovf      = 1'b0;
`endif
endmodule

// File: tb/tb_conf_int_mac_pipe.sv
// Scoreboard bench for conf_int_mac_pipe: directed vectors push expected results,
// a negedge monitor pops and compares on every out_valid && out_ready transfer.
module tb_conf_int_mac_pipe;
    localparam int unsigned OW = 16;
    localparam int unsigned PN = 8;
    localparam int unsigned AW = 40;
`ifdef CONF_MAC_OVF_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] d;
        logic          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   pop_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conf_int_mac_pipe_if #(.OP_BITWIDTH(OW), .ACC_BITWIDTH(AW)) bus ();

    conf_int_mac_pipe #(
        .OP_BITWIDTH (OW),
        .Pn          (PN),
        .ACC_BITWIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic void chk(input string name, input logic [63:0] got,
                                input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endfunction

    // Monitor: every accepted output is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got d=0x%0h, expected no output", bus.d);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_d", 64'(bus.d), 64'(e.d));
                    chk("result_ovf", 64'(bus.ovf), 64'(e.ovf));
                end
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Holds in_valid high on return so consecutive calls issue back-to-back.
    task automatic send(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic [OW-1:0] c,
                        input logic apx, input logic accm, input logic clr,
                        input logic [AW-1:0] exp_d, input logic exp_ovf);
        int   guard;
        exp_t e;
        guard        = 0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
        bus.apx__p   = apx;
        bus.acc_mode = accm;
        bus.acc_clr  = clr;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=0, expected 1");
        end else begin
            e.d   = exp_d;
            e.ovf = exp_ovf;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] acc_tbl [4];
        logic [AW-1:0] macc;
        logic [AW:0]   sum;
        logic          mov;
        int            n;

        acc_tbl[0] = 40'h0FFFE0001;
        acc_tbl[1] = 40'h1FFFC0002;
        acc_tbl[2] = 40'h2FFFA0003;
        acc_tbl[3] = 40'h3FFF80004;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c         = '0;
        bus.apx__p    = 1'b0;
        bus.acc_mode  = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_d", 64'(bus.d), 64'd0);
        chk("reset_ovf", 64'(bus.ovf), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Accurate op and exact 3-cycle latency.
        send(16'h1234, 16'h0056, 16'h0010, 1'b0, 1'b0, 1'b0, 40'h61D88, 1'b0);
        idle();
        chk("latency_c1", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("latency_c2", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("latency_c3", 64'(bus.out_valid), 64'd1);
        wait_drain();

        // Approximate: only aH*bH, c's low 16 bits masked.
        send(16'h12FF, 16'h34FF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 40'h3A80000, 1'b0);
        idle();
        wait_drain();

        // Back-to-back accumulation.
        n = pop_cyc.size();
        for (int i = 0; i < 4; i++) begin
            send(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, (i == 0), acc_tbl[i], 1'b0);
        end
        idle();
        wait_drain();
        if (pop_cyc.size() >= n + 4) begin
            chk("acc_no_bubble", 64'(pop_cyc[n+3] - pop_cyc[n]), 64'd3);
        end else begin
            checks++;
            failures++;
            $display("FAIL acc_no_bubble: got %0d results, expected 4", pop_cyc.size() - n);
        end

        // Overflow: only the 257th addition crosses 2^40.
        macc = '0;
        mov  = 1'b0;
        for (int i = 0; i < 257; i++) begin
            sum  = ((i == 0) ? 41'd0 : {1'b0, macc}) + 41'h0FFFF0000;
            if (sum[AW]) mov = 1'b1;
            macc = sum[AW-1:0];
            send(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, (i == 0),
                 (i == 256) ? 40'h0FEFF0000 : macc, OvfEn & mov);
        end
        idle();
        wait_drain();
        chk("ovf_sticky", 64'(bus.ovf), 64'(OvfEn));
        send(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 40'h0, 1'b0);
        idle();
        wait_drain();
        chk("ovf_cleared", 64'(bus.ovf), 64'd0);

        // Backpressure: first result held while consumer stalls.
        send(16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 40'h5, 1'b0);
        send(16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 40'h10000, 1'b0);
        send(16'h0300, 16'h0005, 16'h0007, 1'b0, 1'b0, 1'b0, 40'hF07, 1'b0);
        idle();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_d", 64'(bus.d), 64'h5);
        end
        bus.out_ready = 1'b1;
        wait_drain();

        // Leave a nonzero accumulator so reset clearing it is visible.
        send(16'h0010, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 40'h100, 1'b0);
        idle();
        wait_drain();

        // Reset with two operations in flight.
        send(16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 40'd25, 1'b0);
        send(16'h0007, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0, 40'd49, 1'b0);
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_d", 64'(bus.d), 64'd0);
        chk("midrst_ovf", 64'(bus.ovf), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0002, 16'h0003, 16'h0001, 1'b0, 1'b1, 1'b0, 40'd7, 1'b0);
        idle();
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conf_int_mac_pipe.md
# conf_int_mac_pipe

Pipelined, parametrised successor of the single-cycle configurable-precision integer MAC. It splits each multiply into four Pn-bit-boundary partial products across registered stages. It adds a running accumulator and a valid/ready handshake, and it keeps the per-operation approximate mode (high×high partial product plus the high part of c only). It sits in the datapath between operand fetch and result writeback, and accepts one operation per cycle when not stalled.

## Interface
- OP_BITWIDTH, 16, width of a, b, c (unsigned)
- Pn, 8, split point; low part = bits [Pn-1:0], high part = bits [OP_BITWIDTH-1:Pn]; legal range 1..OP_BITWIDTH-1
- ACC_BITWIDTH, 40, accumulator and result width; must be ≥ 2*OP_BITWIDTH
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operation present on a/b/c/flags
- in_ready  out  1  block accepts operation this cycle
- a, b, c  in  OP_BITWIDTH each  operands
- apx__p  in  1  1 = approximate mode for this operation
- acc_mode  in  1  1 = add running accumulator to the result
- acc_clr  in  1  1 = treat accumulator as 0 for this operation
- out_valid  out  1  result valid on d
- out_ready  in  1  consumer accepts d
- d  out  ACC_BITWIDTH  result
- ovf  out  1  sticky accumulator overflow (present only with the macro below)

## Operation
- Stage S1 registers LL=aL*bL, HL=aH*bL, LH=aL*bH, HH=aH*bH, plus c, apx__p, acc_mode, acc_clr and a valid bit.
- Stage S2 forms p:
  - accurate: p = (HH<<2Pn) + (LH<<Pn) + (HL<<Pn) + LL = a*b exactly.
  - approximate: p = HH<<2Pn.
- S2 also forms c': c' = c in accurate mode; c' = (c>>2Pn)<<2Pn in approximate mode, i.e. the low 2Pn bits are zeroed.
- Stage S3 computes r = base + p + c', where base = 0 if acc_mode=0 or acc_clr=1, otherwise base = acc.
  - r is computed at ACC_BITWIDTH+1 bits; d and acc receive r[ACC_BITWIDTH-1:0], so the result wraps modulo 2^ACC_BITWIDTH.
  - On each S3 commit: d ← r. If acc_mode=1, acc ← r; otherwise acc is unchanged.
- Back-to-back accumulating operations use the acc value written by the immediately preceding commit, with no bubble.
- All arithmetic is unsigned and zero-extended.

## Timing
- Reset (rst=0, asynchronous) clears all valid bits, acc, d and ovf. Reset values: out_valid=0, d=0, ovf=0, in_ready=1.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en. All stages advance together when en=1.
- An input is accepted when in_valid && in_ready.
- Latency: the result appears on d with out_valid=1 exactly 3 cycles after acceptance, given en held at 1.
- Throughput is 1 operation per cycle.
- Stall: while out_valid && !out_ready, all stage registers, acc and d hold, and in_ready=0.
  - No operation is dropped or duplicated, and order is preserved.
- Bubbles: invalid slots flow through the pipeline and never update acc or d.
- Reset asserted mid-operation discards all in-flight operations.
  - The first operation accepted after rst deasserts behaves as if it were the first operation ever accepted.
- out_valid is held until the consumer accepts; d is stable while out_valid=1 and out_ready=0.

## Configuration
- CONF_MAC_OVF_EN defined:
  - ovf is set on any S3 commit where acc_mode=1 and r[ACC_BITWIDTH]=1.
  - ovf is cleared only by reset or by a commit with acc_clr=1 that itself does not overflow.
- CONF_MAC_OVF_EN undefined: no overflow logic is built, ovf is tied to 0, and wrap behaviour is unchanged.

## Test plan
All scenarios use defaults (16/8/40) unless stated.
- Accurate single operation: a=0x1234, b=0x0056, c=0x0010, apx__p=0, acc_mode=0 -> d=0x61D88 with out_valid exactly 3 cycles after acceptance.
- Approximate operation: a=0x12FF, b=0x34FF, c=0xFFFF, apx__p=1 -> d=0x3A80000 (the c contribution is masked to 0).
- Accumulate: four back-to-back operations a=b=0xFFFF, c=0, acc_mode=1, acc_clr=1 on the first only -> the fourth d=0x3FFF80004, with no bubbles between results.
- Overflow (macro defined): 257 operations a=b=c=0xFFFF, acc_mode=1, acc_clr on the first -> final d=0xFEFF0000 and ovf=1. A following operation with acc_clr=1 and a=b=c=0 -> d=0 and ovf=0.
- Backpressure: issue 3 operations, then hold out_ready=0 for 5 cycles -> in_ready=0 and d stable throughout the stall; all 3 results are then delivered in order with correct values.
- Reset mid-flight: pulse rst low with 2 operations in flight -> out_valid=0, d=0, ovf=0 immediately. After release, one operation a=2, b=3, c=1, acc_mode=1 -> d=7.
